bsg_nasti_req_arbiter: RTL and testbench
========================================

Name: bsg_nasti_req_arbiter

Overview:
- Round-robin arbiter that shares one NASTI master request path between num_in_p tunnel requesters. The shared path accepts bsg_tun_dmx_t words through a valid/yumi interface.
- Sits between the demultiplexed tunnel channels and the NASTI master request converter.
- Read packets are 1 word (address header, rw=0). Write packets are 1 header word (rw=1) followed by wbeats_p data words.
- Grant is locked for a whole write packet, so the converter never sees interleaved beats from different requesters.

Parameters:
- num_in_p, 2, number of requesters (>=2).
- width_p, $bits(bsg_tun_dmx_t), request word width.
- rw_bit_p, index of the rw field of bsg_nasti_sa_pkt within the word; 1 = write header.
- last_bit_p, index of the last field of bsg_nasti_sw_pkt within the word.
- wbeats_p, 8, data beats per write packet (matches AXI len=7).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  num_in_p  per-requester word valid.
- req_data_i  in  num_in_p*width_p  per-requester word; requester i occupies bits [i*width_p +: width_p].
- req_yumi_o  out  num_in_p  per-requester word consumed.
- req_valid_o  out  1  word valid to the converter.
- req_data_o  out  width_p  word to the converter.
- req_yumi_i  in  1  converter consumed the word; only asserted when req_valid_o=1.
- grant_o  out  num_in_p  one-hot current grant; 0 when no requester is selected.
- lock_o  out  1  a write packet is in progress.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, beat counter=0, rr pointer=0 (requester 0 highest priority), err_o=0.
  - While reset_i=1: req_valid_o=0, req_yumi_o=0, grant_o=0, lock_o=0.
- State IDLE (unlocked):
  - Select the first requester with req_valid_i=1, searching cyclically from index ptr.
  - grant_o = that requester (one-hot), or 0 if none is valid.
  - req_valid_o = |req_valid_i; req_data_o = granted word.
  - Selection is combinational, so a new request can be forwarded in the same cycle it appears.
- Header accepted in IDLE (req_yumi_i=1):
  - Header rw=0: read packet complete. ptr <= granted+1 mod num_in_p; stay IDLE.
  - Header rw=1: go to WLOCK, latch the granted index, beat counter <= 0.
- State WLOCK:
  - grant_o = latched index. req_valid_o = req_valid_i[latched]; other requesters are ignored even if valid.
  - Each req_yumi_i=1 increments the beat counter.
  - On yumi of beat wbeats_p-1: return to IDLE, ptr <= latched+1 mod num_in_p, counter <= 0.
  - lock_o=1 only in WLOCK.
- Yumi routing: req_yumi_o = req_yumi_i replicated and ANDed with grant_o. Combinational; no added latency, no storage.
- Error checking: err_o sets (sticky until reset) when the last bit of an accepted data beat disagrees with the counter, i.e. last=1 on beat < wbeats_p-1, or last=0 on beat wbeats_p-1. Packet framing stays counter-based even after an error.
- Beat counter is $clog2(wbeats_p)+1 bits wide and never exceeds wbeats_p-1.
- Idle gaps: a requester dropping valid mid-packet stalls the path; the lock is held indefinitely.
- ptr wraps from num_in_p-1 to 0.
- A read header in IDLE followed by a new request the next cycle is legal; back-to-back packets run at one word per cycle.
- Reset mid-packet (WLOCK) abandons the packet immediately.

Test Plan:
- Reset, then req_valid_i=2'b01 with a read header (rw=0) and req_yumi_i=1 -> same cycle: req_yumi_o=01, grant_o=01. Next cycle: ptr=1, lock_o=0.
- Both requesters hold read headers continuously with yumi every cycle -> grants alternate 01,10,01,10; each requester gets exactly 4 yumis in 8 cycles.
- Requester 0 sends a write header plus 8 beats (last only on beat 7) while requester 1 is valid throughout -> req_yumi_o[1]=0 for all 9 words, lock_o=1 for 8 cycles, then grant_o=10; err_o stays 0.
- Write packet with last=1 on beat 3 -> err_o=1 from the cycle after the beat-3 yumi. Lock still releases after beat 7 and err_o stays 1.
- Converter holds req_yumi_i=0 for 5 cycles mid-burst -> beat counter and grant unchanged, req_data_o stable, no requester yumi.
- Assert reset_i during beat 4 of a write -> lock_o=0, grant_o=0, err_o=0 immediately. After reset, requester 0 wins first arbitration.

Source files
------------

// File: rtl/bsg_nasti_req_arbiter.sv
// Round-robin arbiter sharing one NASTI master request path between tunnel requesters.
// Write packets (header + wbeats_p data beats) hold the grant until their final beat is consumed.
module bsg_nasti_req_arbiter #(
  parameter int num_in_p   = 2,
  parameter int width_p    = 32,
  parameter int rw_bit_p   = 31,
  parameter int last_bit_p = 30,
  parameter int wbeats_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [num_in_p-1:0]          req_valid_i,
  input  logic [num_in_p*width_p-1:0]  req_data_i,
  output logic [num_in_p-1:0]          req_yumi_o,
  output logic                         req_valid_o,
  output logic [width_p-1:0]           req_data_o,
  input  logic                         req_yumi_i,
  output logic [num_in_p-1:0]          grant_o,
  output logic                         lock_o,
  output logic                         err_o
);

  localparam int idx_w_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int cnt_w_lp = $clog2(wbeats_p) + 1;

  typedef enum logic {IDLE, WLOCK} state_e;

  state_e              state_q;
  logic [cnt_w_lp-1:0] cnt_q;
  logic [idx_w_lp-1:0] ptr_q, lock_idx_q;
  logic                err_q;

  logic [idx_w_lp-1:0] sel_idx, scan_idx, cur_idx;
  logic                sel_found, cur_valid, locked, fire, last_beat;
  logic [width_p-1:0]  words [num_in_p];

  function automatic logic [idx_w_lp-1:0] wrap_inc(input logic [idx_w_lp-1:0] i);
    return (i == idx_w_lp'(num_in_p - 1)) ? '0 : i + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < num_in_p; gi++) begin : g_req
      assign words[gi]      = req_data_i[gi*width_p +: width_p];
      assign grant_o[gi]    = !reset_i && (locked || sel_found) && (cur_idx == idx_w_lp'(gi));
      assign req_yumi_o[gi] = req_yumi_i && grant_o[gi];
    end
  endgenerate

  // Cyclic search starting at the round-robin pointer; the first valid requester wins.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    scan_idx  = ptr_q;
    for (int k = 0; k < num_in_p; k++) begin
      if (!sel_found && req_valid_i[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  assign locked      = (state_q == WLOCK);
  assign cur_idx     = locked ? lock_idx_q : sel_idx;
  assign cur_valid   = locked ? req_valid_i[lock_idx_q] : sel_found;
  assign req_valid_o = !reset_i && cur_valid;
  assign req_data_o  = words[cur_idx];
  assign lock_o      = locked;
  assign err_o       = err_q;
  assign fire        = req_yumi_i && req_valid_o;
  assign last_beat   = (cnt_q == cnt_w_lp'(wbeats_p - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else if (fire) begin
      case (state_q)
        IDLE: begin
          if (req_data_o[rw_bit_p]) begin
            state_q    <= WLOCK;
            lock_idx_q <= sel_idx;
            cnt_q      <= '0;
          end else begin
            ptr_q <= wrap_inc(sel_idx);
          end
        end
        WLOCK: begin
          // Framing is counter-driven; a disagreeing last bit only flags the error.
          if (req_data_o[last_bit_p] != last_beat) err_q <= 1'b1;
          if (last_beat) begin
            state_q <= IDLE;
            ptr_q   <= wrap_inc(lock_idx_q);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_nasti_req_arbiter.sv
// Bench for bsg_nasti_req_arbiter: constant vector table, directed packet sequences,
// and randomized traffic checked against a packet-level reference model.
module tb_bsg_nasti_req_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int RW = 31;
  localparam int LB = 30;
  localparam int WB = 8;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_yumi_o;
  logic           req_valid_o;
  logic [W-1:0]   req_data_o;
  logic           req_yumi_i;
  logic [N-1:0]   grant_o;
  logic           lock_o;
  logic           err_o;

  bsg_nasti_req_arbiter #(
    .num_in_p(N), .width_p(W), .rw_bit_p(RW), .last_bit_p(LB), .wbeats_p(WB)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_yumi_o(req_yumi_o),
    .req_valid_o(req_valid_o), .req_data_o(req_data_o), .req_yumi_i(req_yumi_i),
    .grant_o(grant_o), .lock_o(lock_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Packet-level reference state
  int m_ptr, m_owner, m_beats;
  bit m_locked, m_err;

  logic [N-1:0] obs_yumi, obs_grant;
  logic         obs_lock, obs_err;
  logic [W-1:0] obs_data;

  typedef struct {
    logic [N-1:0] vin;
    logic [W-1:0] d0, d1;
    logic         yin;
    logic [N-1:0] grant, yumi;
    logic         valid, lock;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [W-1:0] hdr(input logic rw, input logic [29:0] a);
    return {rw, 1'b0, a};
  endfunction

  function automatic logic [W-1:0] beat(input logic last, input logic [29:0] a);
    return {1'b0, last, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] vin, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic yin);
    req_valid_i = vin;
    req_data_i  = {d1, d0};
    req_yumi_i  = yin;
  endtask

  task automatic model_reset;
    m_ptr = 0; m_owner = 0; m_beats = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_out(output logic v, output logic [N-1:0] g, output int idx);
    idx = 0; v = 1'b0; g = '0;
    if (m_locked) begin
      idx = m_owner;
      v   = req_valid_i[idx];
      g   = N'(1 << idx);
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!v && req_valid_i[j]) begin
          v = 1'b1; idx = j; g = N'(1 << j);
        end
      end
    end
  endtask

  task automatic model_step;
    logic v; logic [N-1:0] g; int idx; logic [W-1:0] w;
    model_out(v, g, idx);
    if (v && req_yumi_i) begin
      w = req_data_i[idx*W +: W];
      if (!m_locked) begin
        if (w[RW]) begin m_locked = 1; m_owner = idx; m_beats = 0; end
        else m_ptr = (idx + 1) % N;
      end else begin
        if (w[LB] != (m_beats == WB - 1)) m_err = 1;
        m_beats++;
        if (m_beats == WB) begin
          m_locked = 0; m_beats = 0; m_ptr = (m_owner + 1) % N;
        end
      end
    end
  endtask

  // Inputs are already driven; compare at the falling edge, advance the model at the rising edge.
  task automatic cycle;
    logic v; logic [N-1:0] g; int idx;
    @(negedge clk_i);
    model_out(v, g, idx);
    chk("valid", 64'(req_valid_o), 64'(v));
    chk("grant", 64'(grant_o), 64'(g));
    chk("yumi", 64'(req_yumi_o), 64'(req_yumi_i ? g : '0));
    chk("lock", 64'(lock_o), 64'(m_locked));
    chk("err", 64'(err_o), 64'(m_err));
    if (v) chk("data", 64'(req_data_o), 64'(req_data_i[idx*W +: W]));
    obs_yumi = req_yumi_o; obs_grant = grant_o; obs_lock = lock_o;
    obs_err = err_o; obs_data = req_data_o;
    @(posedge clk_i);
    model_step;
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    #1;
    chk("rst_valid", 64'(req_valid_o), 64'(0));
    chk("rst_yumi", 64'(req_yumi_o), 64'(0));
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_lock", 64'(lock_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    @(negedge clk_i); @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
  endtask

  initial begin
    int c0, c1, y1, lk;
    logic v; logic [N-1:0] g; int idx;
    logic [W-1:0] w;

    reset_i = 1'b0;
    drive('0, '0, '0, 1'b0);
    model_reset();

    //            vin    d0             d1             yin   grant  yumi   valid lock
    tbl[0] = '{2'b01, hdr(0, 30'h1), hdr(0, 30'h2), 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[1] = '{2'b11, hdr(0, 30'h3), hdr(0, 30'h4), 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[2] = '{2'b11, hdr(0, 30'h5), hdr(0, 30'h6), 1'b1, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[3] = '{2'b11, hdr(0, 30'h7), hdr(0, 30'h8), 1'b0, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[4] = '{2'b01, hdr(0, 30'h9), hdr(0, 30'ha), 1'b0, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[5] = '{2'b00, hdr(0, 30'hb), hdr(0, 30'hc), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[6] = '{2'b10, hdr(0, 30'hd), hdr(1, 30'he), 1'b1, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[7] = '{2'b11, hdr(0, 30'hf), beat(0, 30'h0), 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[8] = '{2'b01, hdr(0, 30'h11), beat(0, 30'h1), 1'b0, 2'b10, 2'b00, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].vin, tbl[i].d0, tbl[i].d1, tbl[i].yin);
      @(negedge clk_i);
      chk("tbl_grant", 64'(grant_o), 64'(tbl[i].grant));
      chk("tbl_yumi", 64'(req_yumi_o), 64'(tbl[i].yumi));
      chk("tbl_valid", 64'(req_valid_o), 64'(tbl[i].valid));
      chk("tbl_lock", 64'(lock_o), 64'(tbl[i].lock));
      if (tbl[i].valid) chk("tbl_data", 64'(req_data_o), 64'(tbl[i].grant[1] ? tbl[i].d1 : tbl[i].d0));
      $display("vec %0d vin=%b yin=%b grant=%b yumi=%b lock=%b", i, tbl[i].vin, tbl[i].yin,
               grant_o, req_yumi_o, lock_o);
      @(posedge clk_i); #1;
    end

    // Table ends mid-write; reset must drop the lock immediately.
    do_reset();

    // Alternating reads from both requesters.
    c0 = 0; c1 = 0;
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, hdr(0, 30'(k)), hdr(0, 30'(k + 100)), 1'b1);
      cycle();
      chk("alt_grant", 64'(obs_grant), 64'((k % 2) ? 2'b10 : 2'b01));
      c0 += int'(obs_yumi[0]); c1 += int'(obs_yumi[1]);
    end
    chk("alt_cnt0", 64'(c0), 64'(4));
    chk("alt_cnt1", 64'(c1), 64'(4));
    $display("seq alternate: yumis r0=%0d r1=%0d", c0, c1);

    // Clean write from requester 0 while requester 1 waits.
    y1 = 0; lk = 0;
    for (int b = -1; b < WB; b++) begin
      drive(2'b11, (b < 0) ? hdr(1, 30'h40) : beat(b == WB - 1, 30'(b)), hdr(0, 30'h50), 1'b1);
      cycle();
      y1 += int'(obs_yumi[1]); lk += int'(obs_lock);
    end
    drive(2'b10, '0, hdr(0, 30'h50), 1'b0);
    cycle();
    chk("wr_grant_after", 64'(obs_grant), 64'(2'b10));
    chk("wr_y1", 64'(y1), 64'(0));
    chk("wr_lockcnt", 64'(lk), 64'(WB));
    chk("wr_err", 64'(obs_err), 64'(0));
    $display("seq write r0: r1 yumis=%0d lock cycles=%0d err=%b", y1, lk, obs_err);

    // Write from requester 1 with a 5-cycle converter stall after beat 2.
    drive(2'b10, '0, hdr(1, 30'h60), 1'b1); cycle();
    for (int b = 0; b < 3; b++) begin drive(2'b10, '0, beat(0, 30'(b)), 1'b1); cycle(); end
    for (int s = 0; s < 5; s++) begin
      drive(2'b10, '0, beat(0, 30'h3), 1'b0); cycle();
      chk("stall_data", 64'(obs_data), 64'(beat(0, 30'h3)));
      chk("stall_yumi", 64'(obs_yumi), 64'(0));
      chk("stall_grant", 64'(obs_grant), 64'(2'b10));
      chk("stall_lock", 64'(obs_lock), 64'(1));
    end
    for (int b = 3; b < WB; b++) begin drive(2'b10, '0, beat(b == WB - 1, 30'(b)), 1'b1); cycle(); end
    drive(2'b00, '0, '0, 1'b0); cycle();
    chk("stall_release", 64'(obs_lock), 64'(0));
    $display("seq stall write r1: lock released=%b", !obs_lock);

    // Write from requester 0 with a premature last on beat 3.
    drive(2'b01, hdr(1, 30'h70), '0, 1'b1); cycle();
    for (int b = 0; b < WB; b++) begin
      drive(2'b01, beat(b == 3 || b == WB - 1, 30'(b)), '0, 1'b1); cycle();
      chk("err_seq", 64'(obs_err), 64'(b >= 4));
    end
    drive(2'b00, '0, '0, 1'b0); cycle();
    chk("err_release", 64'(obs_lock), 64'(0));
    chk("err_sticky", 64'(obs_err), 64'(1));
    $display("seq error write r0: err=%b lock=%b", obs_err, obs_lock);

    // Reset during beat 4 of a write from requester 1.
    drive(2'b10, '0, hdr(1, 30'h80), 1'b1); cycle();
    for (int b = 0; b < 4; b++) begin drive(2'b10, '0, beat(0, 30'(b)), 1'b1); cycle(); end
    drive(2'b10, '0, beat(0, 30'h4), 1'b1);
    #1; reset_i = 1'b1; #1;
    chk("mid_rst_lock", 64'(lock_o), 64'(0));
    chk("mid_rst_grant", 64'(grant_o), 64'(0));
    chk("mid_rst_err", 64'(err_o), 64'(0));
    chk("mid_rst_valid", 64'(req_valid_o), 64'(0));
    chk("mid_rst_yumi", 64'(req_yumi_o), 64'(0));
    @(negedge clk_i); @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    drive(2'b11, hdr(0, 30'h90), hdr(0, 30'h91), 1'b1); cycle();
    chk("post_rst_grant", 64'(obs_grant), 64'(2'b01));
    $display("seq reset mid-write: first grant=%b", obs_grant);

    // Randomized traffic against the reference model, with periodic resets.
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 499) do_reset();
      req_valid_i = N'($urandom);
      for (int i = 0; i < N; i++) begin
        if (m_locked && i == m_owner)
          w = beat((($urandom % 16) == 0) ^ (m_beats == WB - 1), 30'($urandom));
        else
          w = hdr(($urandom % 3) == 0, 30'($urandom));
        req_data_i[i*W +: W] = w;
      end
      model_out(v, g, idx);
      req_yumi_i = v && (($urandom % 4) != 0);
      cycle();
    end
    $display("seq random: 4000 cycles");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
